// File: rtl/tx_byte_serialiser_if.sv
// rtl/tx_byte_serialiser_if.sv - byte-source and bit-sink handshake bundle for the serialiser
interface tx_byte_serialiser_if;
  logic [7:0] in_data;
  logic [2:0] in_data_bits;
  logic       in_data_valid;
  logic       in_req;
  logic       bit_data;
  logic       bit_valid;
  logic       bit_is_parity;
  logic       bit_last;
  logic       bit_req;

  modport master (
    output in_data, in_data_bits, in_data_valid, bit_req,
    input  in_req, bit_data, bit_valid, bit_is_parity, bit_last
  );

  modport slave (
    input  in_data, in_data_bits, in_data_valid, bit_req,
    output in_req, bit_data, bit_valid, bit_is_parity, bit_last
  );
endinterface

// File: rtl/tx_byte_serialiser.sv
// rtl/tx_byte_serialiser.sv - byte to bit serialiser appending an odd-parity bit per byte
module tx_byte_serialiser (
  input  logic                 clk,
  input  logic                 rst_n,
  tx_byte_serialiser_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bits_left_q, bits_left_d;
  logic       parity_q, parity_d;
  logic       in_req_q, in_req_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    parity_d    = parity_q;
    in_req_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_data_valid) begin
          shift_d     = bus.in_data;
          bits_left_d = (bus.in_data_bits == 3'd0) ? 4'd8 : {1'b0, bus.in_data_bits};
          parity_d    = 1'b1;
          in_req_d    = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.bit_req) begin
          parity_d    = parity_q ^ shift_q[0];
          shift_d     = {1'b0, shift_q[7:1]};
          bits_left_d = bits_left_q - 4'd1;
          if (bits_left_q == 4'd1) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        // Follow-on bytes are always whole; the partial width applies to the first byte only.
        if (bus.bit_req) begin
          if (bus.in_data_valid) begin
            shift_d     = bus.in_data;
            bits_left_d = 4'd8;
            parity_d    = 1'b1;
            in_req_d    = 1'b1;
            state_d     = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'd0;
      bits_left_q <= 4'd0;
      parity_q    <= 1'b0;
      in_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      parity_q    <= parity_d;
      in_req_q    <= in_req_d;
    end
  end

  // Outputs decode directly from registered state so the next bit appears on the consuming edge.
  assign bus.in_req        = in_req_q;
  assign bus.bit_valid     = (state_q == ST_DATA) || (state_q == ST_PARITY);
  assign bus.bit_is_parity = (state_q == ST_PARITY);
  assign bus.bit_data      = (state_q == ST_DATA)   ? shift_q[0] :
                             (state_q == ST_PARITY) ? parity_q   : 1'b0;
  assign bus.bit_last      = (state_q == ST_PARITY) && !bus.in_data_valid;

endmodule

// File: tb/tb_tx_byte_serialiser.sv
// tb/tb_tx_byte_serialiser.sv - directed self-checking bench for tx_byte_serialiser
module tb_tx_byte_serialiser;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [7:0] frame [4];

  tx_byte_serialiser_if u_if ();

  tx_byte_serialiser u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] outs();
    return {u_if.in_req, u_if.bit_data, u_if.bit_valid, u_if.bit_is_parity, u_if.bit_last};
  endfunction

  // Drives frame[0..n-1] as the byte source and consumes bits as the encoder,
  // comparing {data, is_parity, last} per bit against the hand-written pattern.
  task automatic run_frame(input int n, input logic [2:0] db, input string pattern,
                           input int gapmax, input int abort_at);
    int nreq, idx, k, budget, g, nb0;
    bit done, started, par;
    logic [2:0] held;
    nreq = 0; idx = 0; k = 0; budget = 0; done = 0; started = 0;
    nb0 = (db == 3'd0) ? 8 : int'(db);
    @(posedge clk); #1;
    u_if.in_data       = frame[0];
    u_if.in_data_bits  = db;
    u_if.in_data_valid = 1'b1;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (u_if.in_req) begin
            nreq++;
            @(posedge clk); #1;
            k++;
            if (k < n) u_if.in_data = frame[k];
            else       u_if.in_data_valid = 1'b0;
          end
        end
      end
      begin
        while (idx < pattern.len() && !done) begin
          @(negedge clk);
          if (!u_if.bit_valid) begin
            if (started) begin
              chk("contiguous_valid", 32'(u_if.bit_valid), 32'd1);
              done = 1;
            end else begin
              budget++;
              if (budget > 50) begin
                chk("first_bit_timeout", 32'(u_if.bit_valid), 32'd1);
                done = 1;
              end
            end
          end else if (idx == abort_at) begin
            #2 rst_n = 1'b0;
            #1 chk("async_reset_outputs", 32'(outs()), 32'd0);
            done = 1;
          end else begin
            started = 1;
            held = {u_if.bit_valid, u_if.bit_data, u_if.bit_is_parity};
            if (gapmax > 0) begin
              g = $urandom_range(gapmax, 0);
              for (int c = 0; c < g; c++) begin
                @(negedge clk);
                chk("hold_during_gap", 32'({u_if.bit_valid, u_if.bit_data, u_if.bit_is_parity}),
                    32'(held));
              end
            end
            par = (idx == nb0) || (idx > nb0 && ((idx - nb0) % 9) == 0);
            chk($sformatf("bit%0d", idx),
                32'({u_if.bit_data, u_if.bit_is_parity, u_if.bit_last}),
                32'({pattern[idx] == "1", par, idx == pattern.len() - 1}));
            u_if.bit_req = 1'b1;
            @(posedge clk); #1;
            u_if.bit_req = 1'b0;
            idx++;
          end
        end
        if (!done && abort_at < 0) begin
          @(negedge clk);
          chk("valid_low_after_frame", 32'(u_if.bit_valid), 32'd0);
        end
        done = 1;
      end
    join
    chk("in_req_pulses", 32'(nreq), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    u_if.in_data       = 8'h00;
    u_if.in_data_bits  = 3'd0;
    u_if.in_data_valid = 1'b0;
    u_if.bit_req       = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(1, 3'd0, "101001011", 0, -1);

    frame = '{8'h93, 8'h20, 8'h00, 8'h00};
    run_frame(2, 3'd0, "110010011000001000", 0, -1);

    frame = '{8'h26, 8'hFF, 8'h00, 8'h00};
    run_frame(2, 3'd7, "01100100111111111", 0, -1);

    frame = '{8'h01, 8'h5A, 8'hC3, 8'h00};
    run_frame(3, 3'd1, "10010110101110000111", 0, -1);

    frame = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(1, 3'd0, "000000001", 0, -1);

    frame = '{8'h93, 8'h20, 8'h00, 8'h00};
    run_frame(2, 3'd0, "110010011000001000", 20, -1);

    // Reset lands while bit 4 of the second byte is on the line.
    frame = '{8'h93, 8'h20, 8'h00, 8'h00};
    run_frame(2, 3'd0, "110010011000001000", 0, 13);
    u_if.in_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("quiet_after_reset", 32'({u_if.in_req, u_if.bit_valid}), 32'd0);
    end

    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(1, 3'd0, "101001011", 0, -1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
